// File: rtl/rbs_pipelined_subtractor_pkg.sv
// Shared constants and slice arithmetic for the pipelined ripple-borrow subtractor
// (the pipelined ripple-carry adder uses the same package).
package rbs_pipelined_subtractor_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;
  localparam int DEF_SW     = DEF_WIDTH / DEF_STAGES;

  typedef struct packed {
    logic              bo;
    logic [DEF_SW-1:0] ds;
  } sliceRes_t;

  // One slice worked in SW+1 bits so the borrow out falls out as the top bit.
  function automatic sliceRes_t subSlice(input logic [DEF_SW-1:0] as,
                                         input logic [DEF_SW-1:0] bs,
                                         input logic              bi);
    logic [DEF_SW:0] full;
    full = {1'b0, as} - {1'b0, bs} - {{DEF_SW{1'b0}}, bi};
    return sliceRes_t'(full);
  endfunction

endpackage

// File: rtl/rbs_pipelined_subtractor_if.sv
// Operand/result handshake bundle: master is the producer/consumer side,
// slave is the subtractor.
interface rbs_pipelined_subtractor_if
  import rbs_pipelined_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout, ovf
  );

endinterface

// File: rtl/rbs_pipelined_subtractor_slice.sv
// Combinational SW-bit ripple-borrow slice: {bo, ds} = as - bs - bi.
module rbs_slice
  import rbs_pipelined_subtractor_pkg::*;
#(
  parameter int SW = DEF_SW
) (
  input  logic [SW-1:0] as,
  input  logic [SW-1:0] bs,
  input  logic          bi,
  output logic [SW-1:0] ds,
  output logic          bo
);

  // The shared helper is fixed at the default slice width; other widths inline it.
  if (SW == DEF_SW) begin : gShared
    sliceRes_t res;
    assign res = subSlice(as, bs, bi);
    assign bo  = res.bo;
    assign ds  = res.ds;
  end else begin : gInline
    assign {bo, ds} = {1'b0, as} - {1'b0, bs} - {{SW{1'b0}}, bi};
  end

endmodule

// File: rtl/rbs_pipelined_subtractor.sv
// Slice-pipelined ripple-borrow subtractor D = A - B - bin with valid/ready and a
// single global stall. Needs STAGES >= 2 and WIDTH a multiple of STAGES.
module rbs_pipelined_subtractor
  import rbs_pipelined_subtractor_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic                       clock,
  input  logic                       rst_n,
  rbs_pipelined_subtractor_if.slave  bus
);

  localparam int SW = WIDTH / STAGES;

  logic                       adv;
  logic [STAGES-1:0]          valid_q, valid_d;
  logic [STAGES-1:0]          borrow_q;
  logic [STAGES-1:0]          stageBo;
  logic [STAGES-1:0]          stageBi;
  logic [STAGES-1:0][SW-1:0]  sliceA, sliceB, stageDs, alignedDs;
  logic                       ovfStage_q, ovfStage_d;
  logic                       outValid_q, bout_q, ovf_q;
  logic [WIDTH-1:0]           d_q;

  assign adv          = !outValid_q || bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : gStage
    if (k == 0) begin : gHead
      assign sliceA[k]  = bus.a[SW-1:0];
      assign sliceB[k]  = bus.b[SW-1:0];
      assign stageBi[k] = bus.bin;
    end else begin : gSkew
      logic [SW-1:0] aDly_q [k];
      logic [SW-1:0] bDly_q [k];

      // Slice k waits k cycles so it meets the borrow rippling up from slice k-1.
      always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < k; j++) begin
            aDly_q[j] <= '0;
            bDly_q[j] <= '0;
          end
        end else if (adv) begin
          aDly_q[0] <= bus.a[k*SW +: SW];
          bDly_q[0] <= bus.b[k*SW +: SW];
          for (int j = 1; j < k; j++) begin
            aDly_q[j] <= aDly_q[j-1];
            bDly_q[j] <= bDly_q[j-1];
          end
        end
      end

      assign sliceA[k]  = aDly_q[k-1];
      assign sliceB[k]  = bDly_q[k-1];
      assign stageBi[k] = borrow_q[k-1];
    end

    rbs_slice #(.SW(SW)) uSlice (
      .as (sliceA[k]),
      .bs (sliceB[k]),
      .bi (stageBi[k]),
      .ds (stageDs[k]),
      .bo (stageBo[k])
    );

    logic [SW-1:0] dsDly_q [STAGES-k];

    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j < STAGES - k; j++) begin
          dsDly_q[j] <= '0;
        end
      end else if (adv) begin
        dsDly_q[0] <= stageDs[k];
        for (int j = 1; j < STAGES - k; j++) begin
          dsDly_q[j] <= dsDly_q[j-1];
        end
      end
    end

    assign alignedDs[k] = dsDly_q[STAGES-1-k];
  end

  assign valid_d = {valid_q[STAGES-2:0], bus.in_valid};

  // Overflow is judged where the top slice resolves, using its skewed operand sign bits.
  assign ovfStage_d = (sliceA[STAGES-1][SW-1] != sliceB[STAGES-1][SW-1]) &&
                      (stageDs[STAGES-1][SW-1] != sliceA[STAGES-1][SW-1]);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      borrow_q   <= '0;
      ovfStage_q <= 1'b0;
      outValid_q <= 1'b0;
      d_q        <= '0;
      bout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (adv) begin
      valid_q    <= valid_d;
      borrow_q   <= stageBo;
      ovfStage_q <= ovfStage_d;
      outValid_q <= valid_q[STAGES-1];
      d_q        <= alignedDs;
      bout_q     <= borrow_q[STAGES-1];
      ovf_q      <= ovfStage_q;
    end
  end

  assign bus.out_valid = outValid_q;
  assign bus.d         = d_q;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_rbs_pipelined_subtractor.sv
// Scoreboard bench for rbs_pipelined_subtractor: expectations are queued on accept
// and compared in order whenever a result is presented.
module tb_rbs_pipelined_subtractor;
  import rbs_pipelined_subtractor_pkg::*;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf;
    int               acceptCycle;
    bit               chkLat;
  } expect_t;

  logic    clock = 1'b0;
  logic    rst_n = 1'b0;
  expect_t sbQueue [$];
  expect_t head, incoming;
  int      assertCount = 0;
  int      failCount   = 0;
  int      cycleCount  = 0;
  bit      latencyMode = 1'b1;

  always #5 clock = ~clock;

  rbs_pipelined_subtractor_if #(.WIDTH(WIDTH)) busIf ();

  rbs_pipelined_subtractor #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (busIf)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model works in plain integers, independent of the slice structure.
  function automatic expect_t modelSub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                       input logic bin);
    expect_t e;
    int      diff;
    diff          = int'(a) - int'(b) - int'(bin);
    e.d           = diff[WIDTH-1:0];
    e.bout        = (diff < 0);
    e.ovf         = (a[WIDTH-1] != b[WIDTH-1]) && (e.d[WIDTH-1] != a[WIDTH-1]);
    e.acceptCycle = 0;
    e.chkLat      = 1'b0;
    return e;
  endfunction

  always @(posedge clock) cycleCount++;

  // Mid-cycle monitor: inputs are stable here, so what it sees is what the next edge does.
  always @(negedge clock) begin
    if (!rst_n) begin
      sbQueue.delete();
    end else begin
      if (busIf.out_valid) begin
        if (sbQueue.size() == 0) begin
          checkOutput("spurious_out_valid", {31'd0, busIf.out_valid}, 32'd0);
        end else begin
          head = sbQueue[0];
          checkOutput("d", {16'd0, busIf.d}, {16'd0, head.d});
          checkOutput("bout", {31'd0, busIf.bout}, {31'd0, head.bout});
          checkOutput("ovf", {31'd0, busIf.ovf}, {31'd0, head.ovf});
          if (busIf.out_ready) begin
            if (head.chkLat) checkOutput("latency", cycleCount - head.acceptCycle, STAGES);
            void'(sbQueue.pop_front());
          end else begin
            checkOutput("in_ready_stall", {31'd0, busIf.in_ready}, 32'd0);
          end
        end
      end
      if (busIf.in_valid && busIf.in_ready) begin
        incoming             = modelSub(busIf.a, busIf.b, busIf.bin);
        incoming.acceptCycle = cycleCount + 1;
        incoming.chkLat      = latencyMode;
        sbQueue.push_back(incoming);
      end
    end
  end

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic bin);
    int tries    = 0;
    bit accepted = 1'b0;
    busIf.in_valid = 1'b1;
    busIf.a        = a;
    busIf.b        = b;
    busIf.bin      = bin;
    while (!accepted && tries < 100) begin
      @(negedge clock);
      accepted = busIf.in_ready;
      @(posedge clock);
      #1;
      tries++;
    end
    if (!accepted) checkOutput("accept_timeout", {31'd0, busIf.in_ready}, 32'd1);
    busIf.in_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    busIf.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    busIf.in_valid = 1'b0;
    while (sbQueue.size() != 0 && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    checkOutput("drain", sbQueue.size(), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_out_valid"}, {31'd0, busIf.out_valid}, 32'd0);
    checkOutput({tag, "_d"}, {16'd0, busIf.d}, 32'd0);
    checkOutput({tag, "_bout"}, {31'd0, busIf.bout}, 32'd0);
    checkOutput({tag, "_ovf"}, {31'd0, busIf.ovf}, 32'd0);
    checkOutput({tag, "_in_ready"}, {31'd0, busIf.in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    busIf.in_valid  = 1'b0;
    busIf.a         = '0;
    busIf.b         = '0;
    busIf.bin       = 1'b0;
    busIf.out_ready = 1'b1;

    repeat (2) @(posedge clock);
    #1;
    checkResetOutputs("reset");
    rst_n = 1'b1;
    idleCycles(1);

    $display("[TB] basic subtraction");
    applyStimulus(16'h1234, 16'h0234, 1'b0);
    waitDrain();

    $display("[TB] borrow ripple and signed wrap");
    applyStimulus(16'h0000, 16'h0001, 1'b0);
    applyStimulus(16'h8000, 16'h0001, 1'b0);
    waitDrain();

    $display("[TB] borrow in with equal operands");
    applyStimulus(16'h5A5A, 16'h5A5A, 1'b1);
    waitDrain();

    $display("[TB] streaming");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
    end
    waitDrain();

    $display("[TB] back-pressure with a bubble");
    latencyMode     = 1'b0;
    busIf.out_ready = 1'b0;
    applyStimulus(16'h0100, 16'h0200, 1'b0);
    applyStimulus(16'hFFFF, 16'h7FFF, 1'b1);
    idleCycles(1);
    applyStimulus(16'h7FFF, 16'h8000, 1'b0);
    applyStimulus(16'hABCD, 16'h1234, 1'b1);
    idleCycles(3);
    busIf.out_ready = 1'b1;
    applyStimulus(16'h4444, 16'h3333, 1'b0);
    waitDrain();
    latencyMode = 1'b1;

    $display("[TB] reset mid-stream");
    applyStimulus(16'h8000, 16'h0001, 1'b0);
    applyStimulus(16'h1111, 16'h2222, 1'b0);
    applyStimulus(16'h3333, 16'h0003, 1'b1);
    applyStimulus(16'h9000, 16'h1000, 1'b0);
    idleCycles(1);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    repeat (2) @(posedge clock);
    #1;
    rst_n = 1'b1;
    idleCycles(8);
    applyStimulus(16'h00F0, 16'h000F, 1'b1);
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
